// File: rtl/reg64.sv
// Parameterised storage register with write enable and synchronous active-low reset.
// dataout comes straight from the flop, so there is no path from any input to it.
module reg64 #(
    parameter int unsigned     WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] datain,
    input  logic             wea,
    output logic [WIDTH-1:0] dataout
);

    // Declaration initialiser sets the power-up value before any reset edge.
    logic [WIDTH-1:0] data_q = RESET_VALUE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else if (wea) begin
            data_q <= datain;
        end
    end

    assign dataout = data_q;

endmodule

// File: tb/tb_reg64.sv
// Self-checking bench for reg64: directed scenarios plus randomized traffic
// compared against a register model kept in the bench.
module tb_reg64;

    localparam int unsigned W = 64;
    localparam logic [W-1:0] RV = '0;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] datain;
    logic         wea;
    logic [W-1:0] dataout;

    int n_cmp;
    int n_bad;
    logic [W-1:0] model;

    reg64 #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .datain  (datain),
        .wea     (wea),
        .dataout (dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, apply the register
    // rule to the model at the rising edge, then settle past the edge.
    task automatic step(input logic r, input logic w, input logic [W-1:0] d);
        @(negedge clk);
        reset_n = r;
        wea     = w;
        datain  = d;
        @(posedge clk);
        if (!r)
            model = RV;
        else if (w)
            model = d;
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if (dataout !== RV) begin
            n_bad++;
            $display("FAIL power_up: got %h want %h", dataout, RV);
        end
        model = RV;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, '0);
            n_cmp++;
            if (dataout !== model) begin
                n_bad++;
                $display("FAIL idle_%0d: got %h want %h", i, dataout, model);
            end
        end
    endtask

    task automatic test_write_ones;
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        n_cmp++;
        if (dataout !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++;
            $display("FAIL write_ones: got %h want %h", dataout,
                     64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 64'h5555);
            n_cmp++;
            if (dataout !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                n_bad++;
                $display("FAIL hold_%0d: got %h want %h", i, dataout,
                         64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        step(1'b1, 1'b0, 'x);
        n_cmp++;
        if (dataout !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++;
            $display("FAIL hold_x: got %h want %h", dataout,
                     64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 1'b1, 64'h5555);
        n_cmp++;
        if (dataout !== 64'h5555) begin
            n_bad++;
            $display("FAIL b2b_first: got %h want %h", dataout, 64'h5555);
        end
        step(1'b1, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
        n_cmp++;
        if (dataout !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            n_bad++;
            $display("FAIL b2b_second: got %h want %h", dataout,
                     64'hA5A5_A5A5_A5A5_A5A5);
        end
    endtask

    task automatic test_reset_priority;
        step(1'b0, 1'b1, 64'h1234);
        n_cmp++;
        if (dataout !== RV) begin
            n_bad++;
            $display("FAIL reset_prio: got %h want %h", dataout, RV);
        end
        #2 datain = 64'hDEAD_BEEF_0000_1111;
        #1;
        n_cmp++;
        if (dataout !== RV) begin
            n_bad++;
            $display("FAIL reset_glitch: got %h want %h", dataout, RV);
        end
        step(1'b0, 1'b1, 64'h7777);
        n_cmp++;
        if (dataout !== RV) begin
            n_bad++;
            $display("FAIL reset_held: got %h want %h", dataout, RV);
        end
        // Release reset with a write pending and wiggle inputs before the edge.
        @(negedge clk);
        reset_n = 1'b1;
        wea     = 1'b1;
        datain  = 64'h1234;
        #1;
        n_cmp++;
        if (dataout !== RV) begin
            n_bad++;
            $display("FAIL comb_path: got %h want %h", dataout, RV);
        end
        #1 datain = 64'h0000_0000_0000_BEEF;
        @(posedge clk);
        model = 64'h0000_0000_0000_BEEF;
        #1;
        n_cmp++;
        if (dataout !== model) begin
            n_bad++;
            $display("FAIL first_write: got %h want %h", dataout, model);
        end
    endtask

    task automatic test_random;
        logic         r;
        logic         w;
        logic [W-1:0] d;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 7) != 0);
            w = $urandom_range(0, 1) == 1;
            d = {$urandom(), $urandom()};
            step(r, w, d);
            n_cmp++;
            if (dataout !== model) begin
                n_bad++;
                $display("FAIL rand_%0d: got %h want %h", i, dataout, model);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b1;
        wea     = 1'b0;
        datain  = '0;
        model   = RV;
        test_reset();
        test_write_ones();
        test_hold();
        test_back_to_back();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg64.md
REG64 -- requirements
Module: reg64

Interface
REQ-001 Parameter WIDTH, default 64, data width in bits of datain and dataout.
REQ-002 Parameter RESET_VALUE, default 64'h0 (WIDTH bits), value loaded into dataout by reset and at power-up.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 datain  input  WIDTH  data to be stored.
REQ-006 wea  input  1  write enable, active-high, sampled on rising clk.
REQ-007 dataout  output  WIDTH  current stored value, driven directly from the storage register.
REQ-008 The design SHALL have one clock (clk) and a synchronous, active-low reset (reset_n); no asynchronous set/reset paths.

Function
REQ-009 On each rising clk edge, reset_n=0 SHALL load RESET_VALUE into the register, regardless of wea and datain.
REQ-010 On each rising clk edge with reset_n=1 and wea=1, the register SHALL load datain.
REQ-011 On each rising clk edge with reset_n=1 and wea=0, the register SHALL hold its value.
REQ-012 Write latency SHALL be one cycle: dataout reflects datain sampled at edge N immediately after edge N, stable until the next updating edge.
REQ-013 dataout SHALL have no combinational path from datain, wea or reset_n; changes between edges SHALL NOT affect dataout.
REQ-014 Reset SHALL take priority over write when both are asserted on the same edge.
REQ-015 All WIDTH bits SHALL be written together; no partial or byte writes.
REQ-016 The register SHALL initialise to RESET_VALUE at power-up/simulation start, so dataout is defined before any reset or write.
REQ-017 Back-to-back writes on consecutive edges SHALL each take effect, with no dead cycle.
REQ-018 X/Z on datain while wea=0 SHALL NOT propagate to dataout.

Reset
REQ-019 reset_n=0 sampled on any edge SHALL set dataout=RESET_VALUE (0x0 by default) after that edge, including mid-operation after earlier writes.
REQ-020 While reset_n stays 0, dataout SHALL remain RESET_VALUE and writes SHALL be ignored.
REQ-021 After reset_n returns to 1, the first edge with wea=1 SHALL write normally.

Verification
REQ-022 Power-up, reset_n=1, wea=0, datain=0 for 10 cycles -> dataout=0x0 throughout.
REQ-023 datain=0xFFFFFFFFFFFFFFFF, wea=1 for one edge, then wea=0 -> dataout=0xFFFFFFFFFFFFFFFF after that edge.
REQ-024 Next, datain=0x5555 with wea=0 for 2 cycles -> dataout stays 0xFFFFFFFFFFFFFFFF.
REQ-025 wea=1, datain=0x5555 on edge N, datain=0xA5A5A5A5A5A5A5A5 on edge N+1 -> dataout=0x5555 after N, 0xA5A5A5A5A5A5A5A5 after N+1.
REQ-026 dataout=0xA5A5A5A5A5A5A5A5, then reset_n=0 and wea=1 with datain=0x1234 on the same edge -> dataout=0x0; datain toggled mid-cycle -> dataout unchanged until the next edge.
